// File: rtl/strategy_combine_pkg.sv
// Shared mode constants and width helpers for the strategy-2 output combiner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package strategy_combine_pkg;

    localparam logic MODE_CONCAT = 1'b0;
    localparam logic MODE_SUM    = 1'b1;

    // One output channel slot holds every lane's result side by side.
    function automatic int slot_width(input int n_lane, input int res_w);
        return n_lane * res_w;
    endfunction

    // Lane sum grows by log2(lanes) bits, which is enough to never overflow.
    function automatic int sum_width(input int n_lane, input int res_w);
        return res_w + $clog2(n_lane);
    endfunction

endpackage

// File: rtl/combine_out_fifo.sv
// Small circular-buffer FIFO for merged groups, wrapping pointers plus occupancy count.
// Latency: a pushed word is visible at dout the cycle after the push edge.
// Backpressure: push is ignored when full (no pass-through); pop is ignored when empty.
module combine_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       core_clk,
    input  logic                       arst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Full is judged on the pre-pop count, so a same-edge pop never makes room.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/strategy_output_combine_pipe.sv
// Stages per-lane results until a full group is present, merges by concat or signed sum, queues the result.
// Latency: last lane captured at E0, group enters the output FIFO at E1, o_valid high after E1.
// Backpressure: with the FIFO full a complete group holds and all lanes see ready low until a pop frees a slot.
module strategy_output_combine_pipe
    import strategy_combine_pkg::*;
#(
    parameter int N_LANE    = 4,
    parameter int N_CH      = 16,
    parameter int RES_W     = 32,
    parameter int OUT_DEPTH = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_mode,
    input  logic [N_LANE-1:0]              i_lane_valid,
    output logic [N_LANE-1:0]              o_lane_ready,
    input  logic [N_LANE*N_CH*RES_W-1:0]   i_lane_result,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [N_CH*N_LANE*RES_W-1:0]   o_result,
    output logic                           o_busy
);

    localparam int SLOT_W = slot_width(N_LANE, RES_W);
    localparam int SUM_W  = sum_width(N_LANE, RES_W);
    localparam int LANE_W = N_CH * RES_W;
    localparam int OUT_W  = N_CH * SLOT_W;
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

    logic [LANE_W-1:0] lane_reg [N_LANE];
    logic [N_LANE-1:0] filled;
    logic              mode_q;
    logic              complete;
    logic              drain;
    logic              first_cap;
    logic [N_LANE-1:0] capture;
    logic [OUT_W-1:0]  merged;
    logic [OUT_W-1:0]  fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [SUM_W-1:0]  acc;
    logic [RES_W-1:0]  lane_v;

    assign complete     = &filled;
    assign drain        = complete & ~fifo_full;
    assign o_lane_ready = ~filled | {N_LANE{drain}};
    assign capture      = i_lane_valid & o_lane_ready;
    // A group starts when the buffer is empty or is being emptied on this very edge.
    assign first_cap    = (|capture) & (~(|filled) | drain);
    assign o_busy       = |filled;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            filled <= '0;
            mode_q <= MODE_CONCAT;
        end else begin
            if (drain) filled <= capture;
            else       filled <= filled | capture;
            if (first_cap) mode_q <= i_mode;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int l = 0; l < N_LANE; l++) begin
            if (capture[l]) lane_reg[l] <= i_lane_result[l*LANE_W +: LANE_W];
        end
    end

    // Sign extension to SUM_W keeps the adder exact; the slot is then sign-filled.
    always_comb begin
        merged = '0;
        acc    = '0;
        lane_v = '0;
        for (int c = 0; c < N_CH; c++) begin
            acc = '0;
            for (int l = 0; l < N_LANE; l++) begin
                lane_v = lane_reg[l][c*RES_W +: RES_W];
                merged[c*SLOT_W + l*RES_W +: RES_W] = lane_v;
                acc = acc + {{(SUM_W-RES_W){lane_v[RES_W-1]}}, lane_v};
            end
            if (mode_q == MODE_SUM) begin
                merged[c*SLOT_W +: SLOT_W] = {{(SLOT_W-SUM_W){acc[SUM_W-1]}}, acc};
            end
        end
    end

    assign pop = o_valid & i_ready;

    combine_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .core_clk (i_clk),
        .arst_n   (i_rst_n),
        .push     (drain),
        .pop      (pop),
        .din      (merged),
        .dout     (fifo_dout),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign o_valid  = (fifo_count != '0);
    assign o_result = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_strategy_output_combine_pipe.sv
// Randomized and directed bench for strategy_output_combine_pipe against a queue-based reference model.
module tb_strategy_output_combine_pipe;

    localparam int N_LANE    = 4;
    localparam int N_CH      = 16;
    localparam int RES_W     = 32;
    localparam int OUT_DEPTH = 2;
    localparam int LW        = N_LANE * N_CH * RES_W;
    localparam int SLOT      = N_LANE * RES_W;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic [3:0]    lane_valid;
    logic [3:0]    lane_ready;
    logic [LW-1:0] lane_result;
    logic          valid;
    logic          ready_in;
    logic [LW-1:0] result;
    logic          busy;

    int checks = 0;
    int errors = 0;

    strategy_output_combine_pipe #(
        .N_LANE    (N_LANE),
        .N_CH      (N_CH),
        .RES_W     (RES_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_mode        (mode),
        .i_lane_valid  (lane_valid),
        .o_lane_ready  (lane_ready),
        .i_lane_result (lane_result),
        .o_valid       (valid),
        .i_ready       (ready_in),
        .o_result      (result),
        .o_busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [31:0]   m_lane [N_LANE][N_CH];
    logic [3:0]    m_filled;
    logic          m_mode;
    logic [LW-1:0] m_q [$];

    function automatic logic [LW-1:0] merge_group();
        logic [LW-1:0]        r;
        longint               s;
        int                   v;
        logic signed [SLOT-1:0] w;
        r = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (m_mode) begin
                s = 0;
                for (int l = 0; l < N_LANE; l++) begin
                    v = m_lane[l][c];
                    s = s + v;
                end
                w = s;
                r[c*SLOT +: SLOT] = w;
            end else begin
                for (int l = 0; l < N_LANE; l++) r[c*SLOT + l*RES_W +: RES_W] = m_lane[l][c];
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] model_ready();
        logic drn;
        drn = (m_filled == 4'hF) && (m_q.size() < OUT_DEPTH);
        return ~m_filled | {4{drn}};
    endfunction

    function automatic logic [LW-1:0] model_head();
        return (m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    function automatic logic [LW-1:0] concat_of(input logic [LW-1:0] lr);
        logic [LW-1:0] r;
        r = '0;
        for (int c = 0; c < N_CH; c++)
            for (int l = 0; l < N_LANE; l++)
                r[c*SLOT + l*RES_W +: RES_W] = lr[(l*N_CH + c)*RES_W +: RES_W];
        return r;
    endfunction

    function automatic int diff_slot(input logic [LW-1:0] a, input logic [LW-1:0] b);
        for (int c = 0; c < N_CH; c++)
            if (a[c*SLOT +: SLOT] !== b[c*SLOT +: SLOT]) return c;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [3:0]    rdy;
        logic [3:0]    cap;
        logic          drn;
        logic          pp;
        logic [LW-1:0] w;
        if (!rst_n) begin
            m_filled = '0;
            m_mode   = 1'b0;
            m_q.delete();
        end else begin
            drn = (m_filled == 4'hF) && (m_q.size() < OUT_DEPTH);
            pp  = (m_q.size() != 0) && ready_in;
            rdy = model_ready();
            cap = lane_valid & rdy;
            w   = merge_group();
            if (pp)  void'(m_q.pop_front());
            if (drn) m_q.push_back(w);
            if (cap != 0 && (m_filled == 0 || drn)) m_mode = mode;
            for (int l = 0; l < N_LANE; l++)
                if (cap[l])
                    for (int c = 0; c < N_CH; c++) m_lane[l][c] = lane_result[(l*N_CH + c)*RES_W +: RES_W];
            m_filled = drn ? cap : (m_filled | cap);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_pattern();
        for (int l = 0; l < N_LANE; l++)
            for (int c = 0; c < N_CH; c++)
                lane_result[(l*N_CH + c)*RES_W +: RES_W] = 32'(32'h100 * l + c);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_LANE * N_CH; i++) lane_result[i*RES_W +: RES_W] = $urandom;
    endtask

    task automatic idle(input int n);
        lane_valid = '0;
        ready_in   = 1'b1;
        repeat (n) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        mode = 1'b0; lane_valid = '0; ready_in = 1'b1; lane_result = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got nonzero exp 0"); end
        checks++; if (lane_ready !== 4'hF) begin errors++; $display("FAIL reset_ready got %b exp 1111", lane_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_concat();
        mode = 1'b0; ready_in = 1'b1; fill_pattern(); lane_valid = 4'hF;
        tick();
        lane_valid = '0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL concat_e0_valid got %b exp 0", valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL concat_e0_busy got %b exp 1", busy); end
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL concat_e1_valid got %b exp 1", valid); end
        checks++;
        if (result[5*SLOT +: SLOT] !== 128'h00000305_00000205_00000105_00000005) begin
            errors++; $display("FAIL concat_slot5 got %h exp %h", result[5*SLOT +: SLOT], 128'h00000305_00000205_00000105_00000005);
        end
        checks++;
        if (result !== model_head()) begin
            errors++; $display("FAIL concat_word slot %0d got %h exp %h", diff_slot(result, model_head()),
                result[diff_slot(result, model_head())*SLOT +: SLOT], model_head()[diff_slot(result, model_head())*SLOT +: SLOT]);
        end
        idle(3);
    endtask

    task automatic test_staggered();
        logic [LW-1:0] exp;
        mode = 1'b0; fill_pattern(); exp = concat_of(lane_result);
        lane_valid = 4'b0101;
        tick();
        lane_valid = '0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (lane_ready !== 4'b1010) begin errors++; $display("FAIL stag_ready_a%0d got %b exp 1010", k, lane_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stag_busy_a%0d got %b exp 1", k, busy); end
            if (k < 2) tick();
        end
        lane_valid = 4'b0010;
        tick();
        lane_valid = '0;
        checks++; if (lane_ready !== 4'b1000) begin errors++; $display("FAIL stag_ready_e3 got %b exp 1000", lane_ready); end
        tick();
        checks++; if (lane_ready !== 4'b1000) begin errors++; $display("FAIL stag_ready_e4 got %b exp 1000", lane_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stag_busy_e4 got %b exp 1", busy); end
        lane_valid = 4'b1000;
        tick();
        lane_valid = '0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stag_valid_e5 got %b exp 0", valid); end
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stag_valid_e6 got %b exp 1", valid); end
        checks++;
        if (result !== exp) begin
            errors++; $display("FAIL stag_word slot %0d got %h exp %h", diff_slot(result, exp),
                result[diff_slot(result, exp)*SLOT +: SLOT], exp[diff_slot(result, exp)*SLOT +: SLOT]);
        end
        idle(3);
    endtask

    task automatic test_sum();
        mode = 1'b1; fill_random();
        for (int l = 0; l < N_LANE; l++) begin
            lane_result[(l*N_CH + 0)*RES_W +: RES_W] = 32'hFFFF_FFFF;
            lane_result[(l*N_CH + 1)*RES_W +: RES_W] = 32'h7FFF_FFFF;
        end
        lane_valid = 4'hF;
        tick();
        lane_valid = '0; mode = 1'b0;
        tick();
        checks++;
        if (result[0 +: SLOT] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFC) begin
            errors++; $display("FAIL sum_slot0 got %h exp %h", result[0 +: SLOT], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFC);
        end
        checks++;
        if (result[SLOT +: SLOT] !== 128'h1_FFFF_FFFC) begin
            errors++; $display("FAIL sum_slot1 got %h exp %h", result[SLOT +: SLOT], 128'h1_FFFF_FFFC);
        end
        checks++;
        if (result !== model_head()) begin
            errors++; $display("FAIL sum_word slot %0d got %h exp %h", diff_slot(result, model_head()),
                result[diff_slot(result, model_head())*SLOT +: SLOT], model_head()[diff_slot(result, model_head())*SLOT +: SLOT]);
        end
        idle(3);
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] exp [3];
        int n;
        ready_in = 1'b0; mode = 1'b0;
        for (int g = 0; g < 3; g++) begin
            fill_random(); exp[g] = concat_of(lane_result);
            lane_valid = 4'hF;
            tick();
        end
        lane_valid = '0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (lane_ready !== 4'h0) begin errors++; $display("FAIL bp_hold_ready%0d got %b exp 0000", k, lane_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_hold_busy%0d got %b exp 1", k, busy); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d got %b exp 1", k, valid); end
            tick();
        end
        ready_in = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (valid) begin
                checks++;
                if (n >= 3) begin
                    errors++; $display("FAIL bp_extra_word got %0d words exp 3", n + 1);
                end else if (result !== exp[n]) begin
                    errors++; $display("FAIL bp_order%0d slot %0d got %h exp %h", n, diff_slot(result, exp[n]),
                        result[diff_slot(result, exp[n])*SLOT +: SLOT], exp[n][diff_slot(result, exp[n])*SLOT +: SLOT]);
                end
                n++;
            end
            if (k == 1) begin
                checks++; if (lane_ready !== 4'hF) begin errors++; $display("FAIL bp_drain_ready got %b exp 1111", lane_ready); end
            end
            if (k == 2) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drained_busy got %b exp 0", busy); end
            end
            tick();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", n); end
        idle(2);
    endtask

    task automatic test_mode_latch();
        logic [LW-1:0] exp;
        ready_in = 1'b1; mode = 1'b0; fill_random(); exp = concat_of(lane_result);
        lane_valid = 4'b0001;
        tick();
        mode = 1'b1; lane_valid = 4'b1110;
        tick();
        lane_valid = '0;
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL latch_valid got %b exp 1", valid); end
        checks++;
        if (result !== exp) begin
            errors++; $display("FAIL latch_concat slot %0d got %h exp %h", diff_slot(result, exp),
                result[diff_slot(result, exp)*SLOT +: SLOT], exp[diff_slot(result, exp)*SLOT +: SLOT]);
        end
        mode = 1'b0;
        idle(3);
    endtask

    task automatic test_reset_mid_group();
        fill_random(); lane_valid = 4'b0011;
        tick();
        lane_valid = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", valid); end
        checks++; if (lane_ready !== 4'hF) begin errors++; $display("FAIL rstmid_ready got %b exp 1111", lane_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_emit%0d got %b exp 0", k, valid); end
        end
    endtask

    task automatic test_back_to_back();
        mode = 1'b0; ready_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            fill_random(); lane_valid = 4'hF;
            tick();
            checks++; if (lane_ready !== 4'hF) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1111", k, lane_ready); end
            if (k >= 1) begin
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b exp 1", k, valid); end
                checks++;
                if (result !== model_head()) begin
                    errors++; $display("FAIL b2b_word%0d slot %0d got %h exp %h", k, diff_slot(result, model_head()),
                        result[diff_slot(result, model_head())*SLOT +: SLOT], model_head()[diff_slot(result, model_head())*SLOT +: SLOT]);
                end
            end
        end
        idle(4);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            lane_valid = 4'($urandom_range(0, 15));
            ready_in   = ($urandom_range(0, 3) != 0);
            mode       = 1'($urandom_range(0, 1));
            fill_random();
            tick();
            checks++; if (lane_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready%0d got %b exp %b", k, lane_ready, model_ready()); end
            checks++; if (valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid%0d got %b exp %b", k, valid, (m_q.size() != 0)); end
            checks++; if (busy !== (|m_filled)) begin errors++; $display("FAIL rnd_busy%0d got %b exp %b", k, busy, |m_filled); end
            checks++;
            if (result !== model_head()) begin
                errors++; $display("FAIL rnd_word%0d slot %0d got %h exp %h", k, diff_slot(result, model_head()),
                    result[diff_slot(result, model_head())*SLOT +: SLOT], model_head()[diff_slot(result, model_head())*SLOT +: SLOT]);
            end
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_concat();
        test_staggered();
        test_sum();
        test_backpressure();
        test_mode_latch();
        test_reset_mid_group();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/strategy_output_combine_pipe.md
# strategy_output_combine_pipe

Parametrised, registered successor of the strategy-2 output combiner. It collects per-lane result vectors from N_LANE compute lanes, which may arrive in different cycles, into a staging buffer. Each complete group is merged per channel, by concatenation or by signed lane sum, into an N_CH-wide output word. Merged groups are queued in a small output FIFO drained with a valid/ready handshake. The block sits between the lane accumulators and the output write-back path.

## Interface
Parameters:
- N_LANE, 4: number of compute lanes; must be ≥2.
- N_CH, 16: channels per lane.
- RES_W, 32: width of one lane result per channel.
- OUT_DEPTH, 2: output FIFO depth; must be ≥1.

Ports:
- i_clk  in  1  single clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_mode  in  1  merge mode: 0 = CONCAT, 1 = SUM.
- i_lane_valid  in  N_LANE  per-lane data valid.
- o_lane_ready  out  N_LANE  per-lane ready.
- i_lane_result  in  N_LANE·N_CH·RES_W  lane l, channel c at bits [(l·N_CH+c)·RES_W +: RES_W].
- o_valid  out  1  output FIFO head valid.
- i_ready  in  1  downstream ready.
- o_result  out  N_CH·N_LANE·RES_W  channel c slot at bits [c·N_LANE·RES_W +: N_LANE·RES_W].
- o_busy  out  1  at least one lane is held in the staging buffer.

## Operation
- Staging buffer: one RES_W·N_CH register per lane, plus a filled[l] flag per lane.
- Lane capture: lane l is captured on an edge where i_lane_valid[l] & o_lane_ready[l] holds. The capture loads the lane's register and sets filled[l].
- Group complete: complete = &filled.
- Drain condition: drain = complete & (fifo_count < OUT_DEPTH).
- Ready: o_lane_ready[l] = ~filled[l] | drain. A new group may start on the same edge the previous group drains.
- On a drain edge:
  - The merged word is written to the FIFO tail.
  - All filled flags clear, except lanes captured on the same edge, which are set.
- Mode latch: the group mode is latched from i_mode on the edge a group's first lane is captured. i_mode changes during a partially filled group are ignored.
- CONCAT: channel slot c = {lane N_LANE-1 ch c, …, lane 0 ch c}.
- SUM:
  - Channel slot c = signed sum over all lanes of ch c.
  - The sum is computed at width RES_W+$clog2(N_LANE), then sign-extended to N_LANE·RES_W.
  - No saturation; the sum cannot overflow at that width.
- FIFO:
  - Circular buffer with wrapping read and write pointers and a count.
  - Push only when count < OUT_DEPTH, evaluated before the same-edge pop; there is no pass-through when full.
  - Pop on o_valid & i_ready.
  - Simultaneous push and pop leaves count unchanged.
- Outputs:
  - o_valid = (count ≠ 0).
  - o_result = FIFO head when o_valid, all-zero otherwise.
  - o_busy = |filled.

## Timing
- Reset values (asynchronous): filled = 0, count = 0, both pointers = 0, latched mode = CONCAT. Resulting outputs: o_valid = 0, o_result = 0, o_busy = 0, o_lane_ready = all ones.
- Reset mid-group discards any partial group and any queued groups.
- Latency:
  - The last lane is captured at edge E0.
  - The group is written to the FIFO at E1, if space is available.
  - o_valid is high in the cycle after E1.
  - Merge arithmetic is combinational from the staging registers into the FIFO write.
- Throughput: one group per cycle when all lanes stream and i_ready = 1.
- Backpressure:
  - FIFO full and group complete: the group holds and o_lane_ready = 0 for all lanes until a pop frees a slot.
  - The drain occurs on the edge after the pop, because the push is gated by the pre-pop count.
- o_lane_ready depends combinationally on the registered flags and count only, never on i_lane_valid.

## Structure
- Shared package strategy_combine_pkg:
  - Mode constants MODE_CONCAT = 1'b0 and MODE_SUM = 1'b1.
  - Functions for the slot width (N_LANE·RES_W) and the sum width (RES_W+$clog2(N_LANE)).
- Sub-module combine_out_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Asynchronous active-low reset.
- The top module holds the staging buffer, mode latch and merge logic.

## Test plan
All scenarios use the default parameters. Lane l, channel c input = 32'h100·l + c unless stated otherwise.
1. Reset check: assert i_rst_n = 0, then release → o_valid = 0, o_result = 0, o_lane_ready = 4'b1111, o_busy = 0.
2. CONCAT, all lanes valid at E0 → o_valid high after E1. Channel 5 slot = {32'h305, 32'h205, 32'h105, 32'h005}.
3. Staggered capture: lanes 0 and 2 at E0, lane 1 at E3, lane 3 at E5.
   - o_lane_ready = 4'b1010 from E0 to E3, then 4'b1000 until E5.
   - o_busy stays high.
   - o_valid goes high after E6.
4. SUM, i_mode = 1:
   - All lanes ch0 = 32'hFFFF_FFFF → slot 0 = 128'hFFFF…FFFC.
   - All lanes ch1 = 32'h7FFF_FFFF → slot 1 = 128'h1_FFFF_FFFC.
5. Backpressure with i_ready = 0 and 3 full groups offered:
   - Two groups are queued.
   - The third group holds with o_lane_ready = 0.
   - Raising i_ready pops the groups in order; the third drains one edge after the first pop. No loss or duplication.
6. Mode latch and reset:
   - Toggle i_mode to 1 after lane 0 is captured in CONCAT → the group is output as CONCAT.
   - A separate partial group interrupted by i_rst_n low → o_busy = 0 and o_valid = 0, and nothing is emitted.
